rvc_ifu_prefetch: RTL and testbench

- Instruction fetch unit between I_MEM and the rvc core decode input.
- Owns the fetch PC and issues sequential word reads to I_MEM, which has a 1-cycle read latency.
- Buffers returned words, each with its PC, in a small FIFO and presents them to the core through a valid/ready handshake.
- Core-driven Redirect (branch/jump) flushes the buffer, kills any in-flight read and restarts fetch at the new PC.

---
 rtl/rvc_ifu_prefetch_pkg.sv | 17 +
 rtl/rvc_sync_fifo.sv | 64 ++++++
 rtl/rvc_ifu_prefetch.sv | 107 ++++++++++
 tb/tb_rvc_ifu_prefetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_ifu_prefetch_pkg.sv
// Shared constants and types for the rvc instruction prefetch unit.
// A fetch entry pairs an instruction word with the PC it was fetched from.
package rvc_ifu_prefetch_pkg;

    localparam logic [31:0] RVC_RESET_PC    = 32'h0000_0000;
    localparam int          RVC_FETCH_DEPTH = 4;

    typedef struct packed {
        logic [31:0] Pc;
        logic [31:0] Inst;
    } t_fetch_entry;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rvc_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with a combinational head read.
// Flush has priority over push and pop; DEPTH must be a power of two.
module rvc_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is only legal when a pop frees the slot at the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/rvc_ifu_prefetch.sv
// Instruction prefetch: owns the fetch PC, issues sequential I_MEM reads
// and queues returned words with their PCs for the core's decode stage.
module rvc_ifu_prefetch
    import rvc_ifu_prefetch_pkg::*;
#(
    parameter int          DEPTH    = RVC_FETCH_DEPTH,
    parameter logic [31:0] RESET_PC = RVC_RESET_PC
) (
    input  logic        Clock,
    input  logic        Rst,
    output logic        IMemRdEn,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemRdData,
    output logic        InstValid,
    output logic [31:0] Instruction,
    output logic [31:0] InstPc,
    input  logic        InstReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_req_pc;
    logic           r_inflight;
    logic           r_kill;
    t_fetch_entry   r_hold;

    t_fetch_entry   w_push_entry;
    t_fetch_entry   w_head;
    logic [CW-1:0]  w_count;
    logic           w_full;
    logic           w_empty;
    logic [CW:0]    w_occupancy;
    logic           w_credit_ok;
    logic           w_issue;
    logic           w_push;
    logic           w_pop;

    // Reserve a slot for the read still in flight; a same-cycle pop earns no credit.
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_credit_ok = (w_occupancy < (CW+1)'(DEPTH));
    assign w_issue     = !Rst && !Redirect && !w_full && w_credit_ok;

    assign IMemRdEn    = w_issue;
    assign IMemAddr    = r_fetch_pc;

    assign w_push_entry.Pc   = r_req_pc;
    assign w_push_entry.Inst = IMemRdData;
    assign w_push      = r_inflight && !r_kill;
    assign w_pop       = InstValid && InstReady;

    assign InstValid   = !w_empty;
    assign Instruction = w_empty ? r_hold.Inst : w_head.Inst;
    assign InstPc      = w_empty ? r_hold.Pc   : w_head.Pc;

    rvc_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(t_fetch_entry))
    ) u_fifo (
        .i_clk   (Clock),
        .i_rst   (Rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (Redirect),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else if (Redirect) begin
            r_fetch_pc <= align_word(RedirectPc);
            r_inflight <= w_issue;
            r_kill     <= w_issue;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= 1'b0;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (w_issue) begin
            r_req_pc <= r_fetch_pc;
        end
    end

    // Keeps the data outputs steady once the FIFO drains.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_hold <= '0;
        end else if (!w_empty) begin
            r_hold <= w_head;
        end
    end

endmodule

// File: tb/tb_rvc_ifu_prefetch.sv
// Bench for rvc_ifu_prefetch: directed scenarios plus a random stream,
// checked every cycle against a queue-based model of the fetch rules.
`timescale 1ns/1ps
module tb_rvc_ifu_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] SALT  = 32'hA5A5_0000;

    logic        Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Rst = 1'b1, Redirect = 1'b0, InstReady = 1'b0;
    logic [31:0] RedirectPc = 32'h0, IMemRdData;
    logic        IMemRdEn, InstValid;
    logic [31:0] IMemAddr, Instruction, InstPc;

    logic        Rst2 = 1'b1, Redirect2 = 1'b0, InstReady2 = 1'b1;
    logic [31:0] RedirectPc2 = 32'h0, IMemRdData2;
    logic        IMemRdEn2, InstValid2;
    logic [31:0] IMemAddr2, Instruction2, InstPc2;

    rvc_ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .Clock(Clock), .Rst(Rst), .IMemRdEn(IMemRdEn), .IMemAddr(IMemAddr),
        .IMemRdData(IMemRdData), .InstValid(InstValid), .Instruction(Instruction),
        .InstPc(InstPc), .InstReady(InstReady), .Redirect(Redirect), .RedirectPc(RedirectPc)
    );

    rvc_ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .Clock(Clock), .Rst(Rst2), .IMemRdEn(IMemRdEn2), .IMemAddr(IMemAddr2),
        .IMemRdData(IMemRdData2), .InstValid(InstValid2), .Instruction(Instruction2),
        .InstPc(InstPc2), .InstReady(InstReady2), .Redirect(Redirect2), .RedirectPc(RedirectPc2)
    );

    // I_MEM: one-cycle read latency, garbage on idle cycles.
    always @(posedge Clock) begin
        IMemRdData  <= IMemRdEn  ? (IMemAddr  ^ SALT) : $urandom;
        IMemRdData2 <= IMemRdEn2 ? (IMemAddr2 ^ SALT) : $urandom;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: expected FIFO contents as a PC queue, fetch PC, pending read.
    logic [31:0] mq[$];
    logic [31:0] m_fpc, m_reqpc;
    bit          m_inflight, m_known;

    logic        o_rden, o_valid;
    logic [31:0] o_addr, o_pc, o_inst;

    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
        bit e_valid, e_rden;
        @(negedge Clock);
        Rst = rst; Redirect = redir; RedirectPc = rpc; InstReady = rdy;
        #1;
        o_rden = IMemRdEn; o_valid = InstValid; o_addr = IMemAddr; o_pc = InstPc; o_inst = Instruction;
        e_valid = (mq.size() > 0);
        e_rden  = !rst && !redir && ((mq.size() + int'(m_inflight)) < DEPTH);
        if (m_known) begin
            check("rden",  32'(o_rden),  32'(e_rden));
            check("addr",  o_addr,       m_fpc);
            check("valid", 32'(o_valid), 32'(e_valid));
            if (e_valid) begin
                check("pc",   o_pc,   mq[0]);
                check("inst", o_inst, mq[0] ^ SALT);
            end
        end
        if (rst) begin
            mq.delete(); m_fpc = 32'h0; m_inflight = 1'b0; m_known = 1'b1;
        end else if (m_known) begin
            if (redir) begin
                mq.delete(); m_fpc = {rpc[31:2], 2'b00}; m_inflight = 1'b0;
            end else begin
                if (e_valid && rdy) void'(mq.pop_front());
                if (m_inflight) mq.push_back(m_reqpc);
                if (e_rden) begin
                    m_reqpc = m_fpc; m_fpc = m_fpc + 32'd4; m_inflight = 1'b1;
                end else begin
                    m_inflight = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_first(input string name, input logic [31:0] exp_pc);
        int n = 0;
        while (!o_valid && n < 10) begin
            step(0, 0, 32'h0, 1);
            n++;
        end
        check({name, "_seen"}, 32'(o_valid), 32'd1);
        check({name, "_pc"}, o_pc, exp_pc);
    endtask

    // Wrapping instance: capture the first four delivered PCs and words.
    logic [31:0] got_pc2[4], got_inst2[4];
    int          n2 = 0;
    initial begin
        repeat (2) @(negedge Clock);
        Rst2 = 1'b0;
    end
    always @(negedge Clock) begin
        if (!Rst2 && InstValid2 && n2 < 4) begin
            got_pc2[n2]   = InstPc2;
            got_inst2[n2] = Instruction2;
            n2++;
        end
    end

    initial begin
        logic [31:0] pcs[$];
        logic [31:0] wrap_exp[4];
        int rd_cnt;
        m_known = 1'b0;
        wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0004;

        // Reset release with the core always ready.
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        check("rst_rden", 32'(o_rden), 32'd0);
        step(0, 0, 32'h0, 1);
        check("k0_valid", 32'(o_valid), 32'd0);
        check("k0_inst",  o_inst, 32'h0);
        check("k0_pc",    o_pc,   32'h0);
        check("k0_rden",  32'(o_rden), 32'd1);
        check("k0_addr",  o_addr, 32'h0);
        step(0, 0, 32'h0, 1);
        check("k1_addr",  o_addr, 32'h4);
        check("k1_valid", 32'(o_valid), 32'd0);
        step(0, 0, 32'h0, 1);
        check("k2_valid", 32'(o_valid), 32'd1);
        check("k2_pc",    o_pc,   32'h0);
        check("k2_inst",  o_inst, 32'hA5A5_0000);
        step(0, 0, 32'h0, 1);
        check("k3_pc",    o_pc,   32'h4);

        // Core stalled for 10 cycles: only DEPTH reads may go out.
        step(1, 0, 32'h0, 0);
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 32'h0, 0);
            if (o_rden) rd_cnt++;
        end
        check("stall_reads", 32'(rd_cnt), 32'd4);
        check("stall_pc",    o_pc,        32'h0);
        pcs.delete();
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 32'h0, 1);
            if (i == 1) begin
                check("resume_rden", 32'(o_rden), 32'd1);
                check("resume_addr", o_addr,      32'd16);
            end
            if (o_valid) pcs.push_back(o_pc);
        end
        for (int i = 0; i < 4; i++)
            check("drain_pc", (i < pcs.size()) ? pcs[i] : 32'hDEAD_BEEF, 32'(4 * i));

        // Redirect with two entries buffered and a read in flight.
        step(1, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0);
        step(0, 1, 32'h0000_0103, 0);
        check("redir_rden", 32'(o_rden), 32'd0);
        step(0, 0, 32'h0, 1);
        check("redir_valid", 32'(o_valid), 32'd0);
        check("redir_addr",  o_addr,       32'h100);
        wait_first("redir_first", 32'h100);

        // Back-to-back redirects: the second target wins.
        step(1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1);
        step(0, 1, 32'h40, 1);
        step(0, 1, 32'h80, 1);
        step(0, 0, 32'h0, 1);
        check("b2b_addr",  o_addr,       32'h80);
        check("b2b_valid", 32'(o_valid), 32'd0);
        wait_first("b2b_first", 32'h80);

        // Reset mid-stream with three entries buffered and a read in flight.
        step(1, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        check("midrst_rden",  32'(o_rden),  32'd0);
        check("midrst_valid", 32'(o_valid), 32'd1);
        step(0, 0, 32'h0, 1);
        check("postrst_valid", 32'(o_valid), 32'd0);
        check("postrst_addr",  o_addr,       32'h0);
        wait_first("postrst_first", 32'h0);

        // Random traffic: stalls, redirects (some near the wrap point), resets.
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst, r_redir, r_rdy;
            logic [31:0] r_pc;
            r_rst   = ($urandom_range(0, 99) == 0);
            r_redir = ($urandom_range(0, 19) == 0);
            r_rdy   = ($urandom_range(0, 9) < 7);
            r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
            step(r_rst, r_redir, r_pc, r_rdy);
        end

        // Wrapping instance results.
        check("wrap_count", 32'(n2), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("wrap_pc",   (i < n2) ? got_pc2[i]   : 32'hDEAD_BEEF, wrap_exp[i]);
            check("wrap_inst", (i < n2) ? got_inst2[i] : 32'hDEAD_BEEF, wrap_exp[i] ^ SALT);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
